// File: rtl/lap_display_ctrl.sv
// Lap-time controller: captures stopwatch epochs into a circular lap buffer and
// streams the two most recent laps to the LCD bridge as 32 character writes.
module lap_display_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [27:0] epoch,
    input  logic        run,
    input  logic        lap,
    input  logic        clear,
    output logic        char_valid,
    output logic        char_row,
    output logic [3:0]  char_col,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic [6:0]  lap_total,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ROW0, ROW1} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state, state_nxt;
    logic [3:0]  col, col_nxt;
    logic        valid_nxt;
    logic        start;
    logic        xfer;
    logic        lap_q, clear_q;
    logic        lap_ev, clear_ev, cap;
    logic [AW-1:0] wptr;
    logic [AW:0] count;
    logic        dirty;
    logic [27:0] lap_mem [DEPTH];
    logic [27:0] snap_a, snap_b;
    logic        a_vld, b_vld;
    logic [6:0]  snap_n;

    // Saturate a binary field to 99 and return its tens or ones digit as ASCII.
    function automatic logic [7:0] dig(input logic [6:0] v, input logic tens);
        logic [6:0] s;
        s = (v > 7'd99) ? 7'd99 : v;
        return tens ? (8'h30 + 8'(s / 7'd10)) : (8'h30 + 8'(s % 7'd10));
    endfunction

    function automatic logic [7:0] row_char(input logic [3:0] c, input logic vld,
                                            input logic [27:0] t, input logic [6:0] idx,
                                            input logic top);
        logic [7:0] ch;
        ch = 8'h20;
        if (!vld) begin
            if (top) begin
                case (c)
                    4'd0: ch = 8'h4E;
                    4'd1: ch = 8'h4F;
                    4'd3: ch = 8'h4C;
                    4'd4: ch = 8'h41;
                    4'd5: ch = 8'h50;
                    4'd6: ch = 8'h53;
                    default: ch = 8'h20;
                endcase
            end
        end else begin
            case (c)
                4'd0:  ch = 8'h4C;
                4'd1:  ch = dig(idx, 1'b1);
                4'd2:  ch = dig(idx, 1'b0);
                4'd4:  ch = dig(t[27:21], 1'b1);
                4'd5:  ch = dig(t[27:21], 1'b0);
                4'd6:  ch = 8'h3A;
                4'd7:  ch = dig(t[20:14], 1'b1);
                4'd8:  ch = dig(t[20:14], 1'b0);
                4'd9:  ch = 8'h3A;
                4'd10: ch = dig(t[13:7], 1'b1);
                4'd11: ch = dig(t[13:7], 1'b0);
                4'd12: ch = 8'h2E;
                4'd13: ch = dig(t[6:0], 1'b1);
                4'd14: ch = dig(t[6:0], 1'b0);
                default: ch = 8'h20;
            endcase
        end
        return ch;
    endfunction

    assign lap_ev   = lap & ~lap_q;
    assign clear_ev = clear & ~clear_q;
    assign cap      = lap_ev & run & ~clear_ev;
    assign xfer     = char_valid & char_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_q      <= 1'b0;
            clear_q    <= 1'b0;
            wptr       <= '0;
            count      <= '0;
            lap_total  <= '0;
            dirty      <= 1'b1;
            state      <= IDLE;
            col        <= '0;
            char_valid <= 1'b0;
        end else begin
            lap_q      <= lap;
            clear_q    <= clear;
            state      <= state_nxt;
            col        <= col_nxt;
            char_valid <= valid_nxt;
            // A new event outranks the refresh start clearing dirty in the same cycle.
            if (clear_ev) begin
                wptr      <= '0;
                count     <= '0;
                lap_total <= '0;
                dirty     <= 1'b1;
            end else if (cap) begin
                wptr      <= wptr + AW'(1);
                count     <= (count == FULL) ? count : count + (AW+1)'(1);
                lap_total <= (lap_total == 7'd99) ? lap_total : lap_total + 7'd1;
                dirty     <= 1'b1;
            end else if (start) begin
                dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (cap)
            lap_mem[wptr] <= epoch;
        if (start) begin
            snap_a <= lap_mem[wptr - AW'(1)];
            snap_b <= lap_mem[wptr - AW'(2)];
            a_vld  <= (count != '0);
            b_vld  <= (count > (AW+1)'(1));
            snap_n <= lap_total;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        valid_nxt = char_valid;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (dirty) begin
                    start     = 1'b1;
                    state_nxt = ROW0;
                    col_nxt   = 4'd0;
                    valid_nxt = 1'b1;
                end
            end
            ROW0: begin
                if (xfer) begin
                    col_nxt = col + 4'd1;
                    if (col == 4'd15)
                        state_nxt = ROW1;
                end
            end
            ROW1: begin
                if (xfer) begin
                    col_nxt = col + 4'd1;
                    if (col == 4'd15) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign char_row = (state == ROW1);
    assign char_col = col;
    assign busy     = (state != IDLE);

    always_comb begin
        char_data = 8'h20;
        if (state == ROW0)
            char_data = row_char(col, a_vld, snap_a, snap_n, 1'b1);
        else if (state == ROW1)
            char_data = row_char(col, b_vld, snap_b, snap_n - 7'd1, 1'b0);
    end

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Self-checking bench for lap_display_ctrl: table-driven lap vectors plus
// multi-cycle sequences, with expected LCD rows checked through a scoreboard.
module tb_lap_display_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [27:0] epoch;
    logic        run, lap, clear;
    logic        char_valid, char_row;
    logic [3:0]  char_col;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [6:0]  lap_total;
    logic        busy;

    lap_display_ctrl #(.DEPTH(8), .AW(3)) dut (
        .clock(clock), .reset_n(reset_n), .epoch(epoch), .run(run), .lap(lap),
        .clear(clear), .char_valid(char_valid), .char_row(char_row),
        .char_col(char_col), .char_data(char_data), .char_ready(char_ready),
        .lap_total(lap_total), .busy(busy)
    );

    always #10 clock = ~clock;

    typedef struct {
        bit    row;
        string s;
    } exp_row_t;

    typedef struct {
        logic [27:0] e;
        logic        r;
        int          tot;
        bit          refresh;
        string       row0;
        string       row1;
    } vec_t;

    localparam string SPACES  = "                ";
    localparam string NO_LAPS = "NO LAPS         ";

    exp_row_t    exp_q[$];
    vec_t        tbl[4];
    int          checks = 0;
    int          failures = 0;

    logic [27:0] mdl_mem[8];
    int          mdl_wp, mdl_cnt, mdl_tot;

    int          pos = 0;
    bit          seq_err = 0;
    bit          cur_row = 0;
    logic [7:0]  act[16];

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, a, e);
        end
    endtask

    function automatic string fmt_row(input logic [27:0] e, input int idx);
        int hh, mm, ss, cc;
        hh = (e[27:21] > 99) ? 99 : int'(e[27:21]);
        mm = (e[20:14] > 99) ? 99 : int'(e[20:14]);
        ss = (e[13:7]  > 99) ? 99 : int'(e[13:7]);
        cc = (e[6:0]   > 99) ? 99 : int'(e[6:0]);
        return $sformatf("L%02d %02d:%02d:%02d.%02d ", idx, hh, mm, ss, cc);
    endfunction

    task automatic push_row(input bit r, input string s);
        exp_row_t x;
        x.row = r;
        x.s   = s;
        exp_q.push_back(x);
    endtask

    task automatic push_refresh();
        if (mdl_cnt == 0) begin
            push_row(1'b0, NO_LAPS);
            push_row(1'b1, SPACES);
        end else begin
            push_row(1'b0, fmt_row(mdl_mem[(mdl_wp + 7) % 8], mdl_tot));
            if (mdl_cnt >= 2)
                push_row(1'b1, fmt_row(mdl_mem[(mdl_wp + 6) % 8], mdl_tot - 1));
            else
                push_row(1'b1, SPACES);
        end
    endtask

    task automatic model_capture(input logic [27:0] e);
        mdl_mem[mdl_wp] = e;
        mdl_wp  = (mdl_wp + 1) % 8;
        mdl_cnt = (mdl_cnt < 8) ? mdl_cnt + 1 : 8;
        mdl_tot = (mdl_tot < 99) ? mdl_tot + 1 : 99;
    endtask

    task automatic model_clear();
        mdl_wp = 0; mdl_cnt = 0; mdl_tot = 0;
    endtask

    task automatic set_vec(input int i, input logic [27:0] e, input logic r, input int tot,
                           input bit rf, input string s0, input string s1);
        tbl[i].e = e; tbl[i].r = r; tbl[i].tot = tot;
        tbl[i].refresh = rf; tbl[i].row0 = s0; tbl[i].row1 = s1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press_lap(input logic [27:0] e, input logic r);
        epoch = e; run = r; lap = 1'b1;
        step();
        lap = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int stable = 0;
        for (int n = 0; n < 2000 && stable < 4; n++) begin
            @(negedge clock);
            if (!busy && !char_valid) stable++;
            else stable = 0;
        end
        checks++;
        if (stable < 4) begin
            failures++;
            $display("FAIL %s_idle_timeout actual=busy expected=idle", name);
        end
        chk({name, "_rows_left"}, exp_q.size(), 0);
        step();
    endtask

    task automatic wait_col(input string name, input bit r, input logic [3:0] c);
        bit found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clock);
            if (busy && char_row == r && char_col == c) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_wait_col actual=not_reached expected=col%0d", name, c);
        end
    endtask

    task automatic check_row();
        exp_row_t x;
        string    s = "";
        for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, act[i]);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL row_unexpected actual=\"%s\" expected=none", s);
        end else begin
            x = exp_q.pop_front();
            if (seq_err || s != x.s || cur_row != x.row) begin
                failures++;
                $display("FAIL row%0d actual=\"%s\" row=%0d seq_err=%0d expected=\"%s\"",
                         x.row, s, cur_row, seq_err, x.s);
            end
        end
    endtask

    // Transfer monitor: a write is accepted on the posedge following a negedge
    // where valid and ready are both high.
    always @(negedge clock) begin
        if (!reset_n) begin
            pos = 0;
            seq_err = 0;
        end else if (char_valid && char_ready) begin
            if (pos == 0) cur_row = char_row;
            if (char_col != 4'(pos) || char_row != cur_row) seq_err = 1;
            act[pos] = char_data;
            pos++;
            if (pos == 16) begin
                check_row();
                pos = 0;
                seq_err = 0;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  hold_data;
        logic [3:0]  hold_col;
        logic [27:0] e;

        set_vec(0, {7'd1, 7'd2, 7'd3, 7'd45}, 1'b1, 1, 1'b1, "L01 01:02:03.45 ", SPACES);
        set_vec(1, {7'd9, 7'd9, 7'd9, 7'd9},  1'b0, 1, 1'b0, "", "");
        set_vec(2, {7'd23, 7'd59, 7'd59, 7'd99}, 1'b1, 2, 1'b1, "L02 23:59:59.99 ", "L01 01:02:03.45 ");
        set_vec(3, {7'd127, 7'd100, 7'd5, 7'd7}, 1'b1, 3, 1'b1, "L03 99:99:05.07 ", "L02 23:59:59.99 ");

        reset_n = 1'b0; epoch = '0; run = 1'b0; lap = 1'b0; clear = 1'b0; char_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        chk("rst_valid", char_valid, 0);
        chk("rst_data", char_data, 8'h20);
        chk("rst_total", lap_total, 0);
        chk("rst_busy", busy, 0);
        chk("rst_col", char_col, 0);
        chk("rst_row", char_row, 0);
        push_refresh();
        step();
        reset_n = 1'b1;
        wait_idle("boot");
        chk("boot_total", lap_total, 0);

        for (int i = 0; i < 4; i++) begin
            press_lap(tbl[i].e, tbl[i].r);
            if (tbl[i].r) model_capture(tbl[i].e);
            if (tbl[i].refresh) begin
                push_row(1'b0, tbl[i].row0);
                push_row(1'b1, tbl[i].row1);
            end
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_total", i), lap_total, 32'(tbl[i].tot));
        end

        clear = 1'b1; step(); clear = 1'b0;
        model_clear(); push_refresh();
        wait_idle("clear");
        chk("clear_total", lap_total, 0);

        epoch = {7'd0, 7'd1, 7'd2, 7'd3}; run = 1'b1; lap = 1'b1;
        model_capture(epoch); push_refresh();
        repeat (100) step();
        lap = 1'b0;
        wait_idle("hold");
        chk("hold_total", lap_total, 1);

        clear = 1'b1; step(); clear = 1'b0;
        model_clear(); push_refresh();
        wait_idle("clear2");
        for (int i = 0; i < 100; i++) begin
            e = {7'(i), 7'(i + 10), 7'(i + 20), 7'(i + 30)};
            press_lap(e, 1'b1);
            model_capture(e); push_refresh();
            wait_idle($sformatf("lap%0d", i));
            if (i == 9) chk("ten_total", lap_total, 10);
        end
        chk("sat_total", lap_total, 99);

        epoch = {7'd5, 7'd5, 7'd5, 7'd5}; run = 1'b1; lap = 1'b1; clear = 1'b1;
        step();
        lap = 1'b0; clear = 1'b0;
        model_clear(); push_refresh();
        wait_idle("lapclr");
        chk("lapclr_total", lap_total, 0);

        e = {7'd2, 7'd30, 7'd15, 7'd50};
        press_lap(e, 1'b1);
        model_capture(e); push_refresh();
        wait_col("stall", 1'b0, 4'd5);
        step();
        char_ready = 1'b0;
        hold_col = char_col;
        hold_data = char_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_valid", k), char_valid, 1);
            chk($sformatf("stall%0d_col", k), char_col, 32'(hold_col));
            chk($sformatf("stall%0d_data", k), char_data, 32'(hold_data));
        end
        step();
        char_ready = 1'b1;
        e = {7'd3, 7'd31, 7'd16, 7'd51};
        press_lap(e, 1'b1);
        model_capture(e); push_refresh();
        wait_idle("midlap");
        chk("midlap_total", lap_total, 2);

        e = {7'd4, 7'd0, 7'd0, 7'd1};
        press_lap(e, 1'b1);
        model_capture(e); push_refresh();
        wait_col("arst", 1'b0, 4'd7);
        #5;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", char_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_total", lap_total, 0);
        chk("arst_data", char_data, 8'h20);
        exp_q.delete();
        model_clear(); push_refresh();
        repeat (2) step();
        reset_n = 1'b1;
        wait_idle("arst");
        chk("arst_after_total", lap_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lap_display_ctrl.md
Name: lap_display_ctrl

Overview:
- Lap-time controller between the stopwatch datapath and the LCD bridge.
- Captures the packed stopwatch epoch on each lap press into a circular lap buffer, and clears the buffer on the clear button.
- Sequences character writes so the LCD shows the two most recent laps, using a valid/ready character handshake toward the LCD driver.

Parameters:
- DEPTH, 8, number of lap entries held; power of two, min 2.
- AW, 3, log2(DEPTH), buffer address width.

Ports:
- clock  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous active-low reset.
- epoch  input  28  packed time: [6:0] centiseconds, [13:7] seconds, [20:14] minutes, [27:21] hours; each field binary.
- run  input  1  timer running (key FSM run_timer).
- lap  input  1  debounced lap button, active-high level.
- clear  input  1  debounced clear button, active-high level.
- char_valid  output  1  character write request.
- char_row  output  1  LCD row (0 = top).
- char_col  output  4  LCD column 0..15.
- char_data  output  8  ASCII character.
- char_ready  input  1  LCD bridge can accept (not busy).
- lap_total  output  7  laps captured since clear, saturates at 99.
- busy  output  1  refresh in progress.

Behaviour:
- Reset values:
  - All outputs 0; char_data = 8'h20.
  - Buffer empty; write pointer 0.
  - Edge registers 0.
  - dirty = 1, so the first refresh starts right after reset release.
- Edge detect: lap and clear are each registered once. An event is input = 1 while the previous sample = 0, evaluated at the same clock edge. Level-held buttons produce one event.
- Lap event with run = 1:
  - At that edge, write the epoch sampled at that edge to buf[wptr].
  - wptr += 1, wrapping modulo DEPTH.
  - count = min(count+1, DEPTH); lap_total = min(lap_total+1, 99).
  - Set dirty.
- Lap event with run = 0: ignored, no state change.
- Full buffer: the oldest entry is overwritten; count stays DEPTH.
- Clear event: count = 0, wptr = 0, lap_total = 0, dirty = 1.
  - A clear event in the same cycle as a lap event wins; the lap is dropped.
- Refresh FSM states: IDLE, ROW0, ROW1.
  - IDLE: when dirty = 1, clear dirty, latch snapshot A = buf[wptr-1] and B = buf[wptr-2] with the valid flags (count >= 1, count >= 2), latch index N = lap_total, then go to ROW0 col 0.
  - ROW0 / ROW1: drive char_valid = 1 with row/col/data. A transfer occurs on an edge where char_valid & char_ready; then col += 1. After col 15 is transferred, ROW0 goes to ROW1 col 0 and ROW1 goes to IDLE.
  - char_valid is registered and stays high until transfer. row/col/data stay stable while valid and not ready.
  - busy = 1 in ROW0 and ROW1.
- Row format, 16 chars: "L" + 2-digit decimal index + space + "HH:MM:SS.CC" + space.
  - Row 0 shows A with index N; row 1 shows B with index N-1.
  - Digits are ASCII 8'h30 + BCD digit. Any field > 99 displays "99".
- Empty rows:
  - count = 0: row 0 is "NO LAPS" padded with spaces; row 1 is all spaces.
  - count = 1: row 1 is all spaces.
- Events during refresh update the buffer and set dirty. The in-flight refresh completes from its latched snapshot, then a new refresh starts from IDLE.
- Minimum refresh duration is 32 transfers; with char_ready tied high, 32 cycles plus 1 IDLE cycle.
- reset_n low at any time, including mid-refresh: asynchronous return to reset values; char_valid drops immediately.

Test Plan:
- Reset release, char_ready = 1 -> 32 transfers; row 0 reads "NO LAPS" + 9 spaces; row 1 is 16 spaces; then busy = 0 and lap_total = 0.
- run = 1, epoch = {7'd1, 7'd2, 7'd3, 7'd45}, lap pulse -> lap_total = 1; row 0 = "L01 01:02:03.45 "; row 1 = spaces.
- Hold lap high for 100 cycles with run = 1 -> exactly one capture; lap_total = 1.
- 10 laps with run = 1 -> count = 8; rows show indices 10 and 09 with the last two epochs; after 100 laps, lap_total stays 99.
- lap and clear rising on the same edge -> lap_total = 0; refresh shows "NO LAPS".
- char_ready low for 5 cycles mid-row -> char_valid, col and data held constant; no column skipped. Lap during refresh -> a second full refresh follows. reset_n low mid-row -> char_valid = 0 immediately.
